vrf_write_record_table: RTL and testbench

//  Keeps one record per in-flight lane instruction: register footprint (vd/vs1/vs2), instruction index and
//  per-element-group write-completion mask. Feeds the record vector to the per-slot write hazard checkers.

---
 rtl/vrf_record_pkg.sv | 35 +++
 rtl/vrf_write_record_table_if.sv | 34 +++
 rtl/vrf_record_slot.sv | 72 +++++++
 rtl/vrf_write_record_table.sv | 78 +++++++
 tb/tb_vrf_write_record_table.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vrf_record_pkg.sv
// Shared types, sizing constants and the instruction-age helper for the VRF write record table.
package vrf_record_pkg;

  localparam int unsigned SLOTS       = 4;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned GRP_PER_REG = 8;
  localparam int unsigned OFF_W       = 3;
  localparam int unsigned MASK_W      = 8 * GRP_PER_REG;
  localparam int unsigned GI_W        = $clog2(MASK_W);

  typedef struct packed {
    logic              vd_valid;
    logic [4:0]        vd;
    logic              vs1_valid;
    logic [4:0]        vs1;
    logic [4:0]        vs2;
    logic [IDX_W-1:0]  instIndex;
    logic              gather;
    logic              gather16;
    logic              onlyRead;
    logic [MASK_W-1:0] elementMask;
  } record_t;

  // a is older than b; the index MSB is a wrap bit that flips the low-bit ordering
  function automatic logic older(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
    return (a[IDX_W-2:0] < b[IDX_W-2:0]) ^ a[IDX_W-1] ^ b[IDX_W-1];
  endfunction

  // Mask bit for a register offset (0..7 within the footprint) and an element group
  function automatic logic [GI_W-1:0] grp_index(input logic [2:0] rel,
                                                input logic [OFF_W-1:0] off);
    return {rel, off};
  endfunction

endpackage

// File: rtl/vrf_write_record_table_if.sv
// Enqueue / write / finish / RAW-query bus of the VRF write record table.
interface vrf_write_record_table_if;
  import vrf_record_pkg::*;

  logic                   enq_valid;
  logic                   enq_ready;
  record_t                enq_rec;
  logic                   wr_valid;
  logic [4:0]             wr_vd;
  logic [OFF_W-1:0]       wr_offset;
  logic [IDX_W-1:0]       wr_instIndex;
  logic                   fin_valid;
  logic [IDX_W-1:0]       fin_instIndex;
  logic                   rd_valid;
  logic [4:0]             rd_vs;
  logic [OFF_W-1:0]       rd_offset;
  logic [IDX_W-1:0]       rd_instIndex;
  logic                   rd_conflict;
  logic [SLOTS-1:0]       rec_valid;
  record_t [SLOTS-1:0]    rec_bits;

  modport master (
    output enq_valid, enq_rec, wr_valid, wr_vd, wr_offset, wr_instIndex,
           fin_valid, fin_instIndex, rd_valid, rd_vs, rd_offset, rd_instIndex,
    input  enq_ready, rd_conflict, rec_valid, rec_bits
  );

  modport slave (
    input  enq_valid, enq_rec, wr_valid, wr_vd, wr_offset, wr_instIndex,
           fin_valid, fin_instIndex, rd_valid, rd_vs, rd_offset, rd_instIndex,
    output enq_ready, rd_conflict, rec_valid, rec_bits
  );

endinterface

// File: rtl/vrf_record_slot.sv
// One record slot: holds the footprint and group-written mask of a single in-flight instruction,
// applies load/finish/write updates and reports whether it blocks the current RAW query.
module vrf_record_slot
  import vrf_record_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_load,
  input  record_t          enq_rec,
  input  logic             wr_valid,
  input  logic [4:0]       wr_vd,
  input  logic [OFF_W-1:0] wr_offset,
  input  logic [IDX_W-1:0] wr_instIndex,
  input  logic             fin_valid,
  input  logic [IDX_W-1:0] fin_instIndex,
  input  logic [4:0]       rd_vs,
  input  logic [OFF_W-1:0] rd_offset,
  input  logic [IDX_W-1:0] rd_instIndex,
  output logic             valid,
  output record_t          rec,
  output logic             freeing,
  output logic             rd_hit
);

  logic    valid_q, valid_d;
  record_t rec_q, rec_d;
  logic [4:0] wr_rel, rd_rel;
  logic    wr_hit;

  // Offsets are modulo-32 register distances from the destination base
  always_comb begin
    wr_rel  = wr_vd - rec_q.vd;
    rd_rel  = rd_vs - rec_q.vd;
    wr_hit  = wr_valid && valid_q && rec_q.vd_valid && (rec_q.instIndex == wr_instIndex) &&
              (wr_rel < 5'd8);
    freeing = fin_valid && valid_q && (rec_q.instIndex == fin_instIndex);
    rd_hit  = valid_q && rec_q.vd_valid && (rec_q.instIndex != rd_instIndex) &&
              older(rec_q.instIndex, rd_instIndex) && (rd_rel < 5'd8) &&
              !rec_q.elementMask[grp_index(rd_rel[2:0], rd_offset)];
  end

  // Next state: a load wins (slot is free or being freed), then finish, then write
  always_comb begin
    valid_d = valid_q;
    rec_d   = rec_q;
    if (enq_load) begin
      valid_d           = 1'b1;
      rec_d             = enq_rec;
      rec_d.elementMask = '0;
    end else if (freeing) begin
      valid_d           = 1'b0;
      rec_d.elementMask = '0;
    end else if (wr_hit) begin
      rec_d.elementMask[grp_index(wr_rel[2:0], wr_offset)] = 1'b1;
    end
  end

  // Slot state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      rec_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rec_q   <= rec_d;
    end
  end

  assign valid = valid_q;
  assign rec   = rec_q;

endmodule

// File: rtl/vrf_write_record_table.sv
// VRF write record table: tracks in-flight writers per slot and answers one RAW query per cycle.
// Optional VRF_RECORD_BYPASS_EN lets an enqueue reuse a slot freed by a finish in the same cycle.
module vrf_write_record_table
  import vrf_record_pkg::*;
(
  input logic                      clock,
  input logic                      reset,
  vrf_write_record_table_if.slave  bus
);

  logic [SLOTS-1:0]    valid, freeing, hit, cand, load, dup;
  record_t [SLOTS-1:0] recs;
  logic                enq_ready, enq_fire, rd_conflict_q;

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    vrf_record_slot u_slot (
      .clock         (clock),
      .reset         (reset),
      .enq_load      (load[g]),
      .enq_rec       (bus.enq_rec),
      .wr_valid      (bus.wr_valid),
      .wr_vd         (bus.wr_vd),
      .wr_offset     (bus.wr_offset),
      .wr_instIndex  (bus.wr_instIndex),
      .fin_valid     (bus.fin_valid),
      .fin_instIndex (bus.fin_instIndex),
      .rd_vs         (bus.rd_vs),
      .rd_offset     (bus.rd_offset),
      .rd_instIndex  (bus.rd_instIndex),
      .valid         (valid[g]),
      .rec           (recs[g]),
      .freeing       (freeing[g]),
      .rd_hit        (hit[g])
    );
  end

  // Slot allocation: lowest free slot, or (with bypass) lowest slot freed this cycle
  always_comb begin
    logic found;
`ifdef VRF_RECORD_BYPASS_EN
    enq_ready = (|(~valid)) | (|freeing);
    cand      = (|(~valid)) ? ~valid : freeing;
`else
    enq_ready = |(~valid);
    cand      = ~valid;
`endif
    enq_fire = bus.enq_valid && enq_ready;
    load     = '0;
    found    = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!found && cand[i]) begin
        load[i] = enq_fire;
        found   = 1'b1;
      end
    end
  end

  // Live slots (not being finished) that already own the offered instruction index
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      dup[i] = valid[i] && !freeing[i] && (recs[i].instIndex == bus.enq_rec.instIndex);
    end
  end

  enq_unique_a: assert property (@(posedge clock) disable iff (!reset) !(enq_fire && (|dup)));

  // RAW answer registered from pre-update slot state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_conflict_q <= 1'b0;
    else        rd_conflict_q <= bus.rd_valid && (|hit);
  end

  assign bus.enq_ready   = enq_ready;
  assign bus.rd_conflict = rd_conflict_q;
  assign bus.rec_valid   = valid;
  assign bus.rec_bits    = recs;

endmodule

// File: tb/tb_vrf_write_record_table.sv
// Self-checking bench for vrf_write_record_table: directed scenarios plus random traffic
// against a slot-array reference model.
module tb_vrf_write_record_table;
  import vrf_record_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  vrf_write_record_table_if bus ();

  vrf_write_record_table dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic    m_valid [SLOTS];
  record_t m_rec   [SLOTS];
  logic    m_conf;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Age rule written on plain integers
  function automatic bit m_older(input int a, input int b);
    return ((a % 4) < (b % 4)) != ((a / 4) != (b / 4));
  endfunction

  function automatic int m_rel(input int to, input int from);
    return (to - from + 32) % 32;
  endfunction

  function automatic bit m_bypass();
`ifdef VRF_RECORD_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle();
    bus.enq_valid     = 1'b0;
    bus.enq_rec       = '0;
    bus.wr_valid      = 1'b0;
    bus.wr_vd         = '0;
    bus.wr_offset     = '0;
    bus.wr_instIndex  = '0;
    bus.fin_valid     = 1'b0;
    bus.fin_instIndex = '0;
    bus.rd_valid      = 1'b0;
    bus.rd_vs         = '0;
    bus.rd_offset     = '0;
    bus.rd_instIndex  = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < SLOTS; i++) begin
      m_valid[i] = 1'b0;
      m_rec[i]   = '0;
    end
    m_conf = 1'b0;
  endtask

  // One clock: check ready, advance model with current inputs, compare after the edge
  task automatic step();
    logic    n_valid [SLOTS];
    record_t n_rec   [SLOTS];
    bit      freed   [SLOTS];
    bit      any_free, any_freed, exp_ready, conf;
    int      slot, rel;
    logic [SLOTS-1:0] vexp;
    #1;
    any_free  = 0;
    any_freed = 0;
    for (int i = 0; i < SLOTS; i++) begin
      freed[i] = bus.fin_valid && m_valid[i] && (int'(m_rec[i].instIndex) == int'(bus.fin_instIndex));
      if (!m_valid[i]) any_free = 1;
      if (freed[i]) any_freed = 1;
    end
    exp_ready = any_free || (m_bypass() && any_freed);
    check("enq_ready", 128'(bus.enq_ready), 128'(exp_ready));
    conf = 0;
    for (int i = 0; i < SLOTS; i++) begin
      rel = m_rel(int'(bus.rd_vs), int'(m_rec[i].vd));
      if (bus.rd_valid && m_valid[i] && m_rec[i].vd_valid &&
          int'(m_rec[i].instIndex) != int'(bus.rd_instIndex) &&
          m_older(int'(m_rec[i].instIndex), int'(bus.rd_instIndex)) && rel < 8 &&
          !m_rec[i].elementMask[rel * 8 + int'(bus.rd_offset)])
        conf = 1;
    end
    for (int i = 0; i < SLOTS; i++) begin
      n_valid[i] = m_valid[i];
      n_rec[i]   = m_rec[i];
      rel = m_rel(int'(bus.wr_vd), int'(m_rec[i].vd));
      if (freed[i]) begin
        n_valid[i] = 1'b0;
        n_rec[i].elementMask = '0;
      end else if (bus.wr_valid && m_valid[i] && m_rec[i].vd_valid &&
                   int'(m_rec[i].instIndex) == int'(bus.wr_instIndex) && rel < 8) begin
        n_rec[i].elementMask[rel * 8 + int'(bus.wr_offset)] = 1'b1;
      end
    end
    if (bus.enq_valid && exp_ready) begin
      slot = -1;
      for (int i = 0; i < SLOTS; i++) if (slot < 0 && !m_valid[i]) slot = i;
      for (int i = 0; i < SLOTS; i++) if (slot < 0 && freed[i]) slot = i;
      n_valid[slot] = 1'b1;
      n_rec[slot] = bus.enq_rec;
      n_rec[slot].elementMask = '0;
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < SLOTS; i++) begin
      m_valid[i] = n_valid[i];
      m_rec[i]   = n_rec[i];
      vexp[i]    = n_valid[i];
    end
    m_conf = conf;
    check("rec_valid", 128'(bus.rec_valid), 128'(vexp));
    for (int i = 0; i < SLOTS; i++) check($sformatf("rec_bits[%0d]", i), 128'(bus.rec_bits[i]),
                                          128'(m_rec[i]));
    check("rd_conflict", 128'(bus.rd_conflict), 128'(m_conf));
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    #1;
    check("rst_rec_valid", 128'(bus.rec_valid), 128'(0));
    check("rst_enq_ready", 128'(bus.enq_ready), 128'(1));
    check("rst_rd_conflict", 128'(bus.rd_conflict), 128'(0));
    model_clear();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic enq(input int vd, input int idx);
    record_t r;
    r           = '0;
    r.vd_valid  = 1'b1;
    r.vd        = 5'(vd);
    r.vs1_valid = 1'b1;
    r.vs1       = 5'($urandom);
    r.vs2       = 5'($urandom);
    r.instIndex = IDX_W'(idx);
    r.gather    = 1'($urandom);
    bus.enq_valid = 1'b1;
    bus.enq_rec   = r;
    step();
    idle();
  endtask

  task automatic rd(input int vs, input int off, input int idx);
    bus.rd_valid     = 1'b1;
    bus.rd_vs        = 5'(vs);
    bus.rd_offset    = OFF_W'(off);
    bus.rd_instIndex = IDX_W'(idx);
    step();
    idle();
  endtask

  task automatic wr(input int vd, input int off, input int idx);
    bus.wr_valid     = 1'b1;
    bus.wr_vd        = 5'(vd);
    bus.wr_offset    = OFF_W'(off);
    bus.wr_instIndex = IDX_W'(idx);
    step();
    idle();
  endtask

  initial begin
    int vq[$];
    int used[$];
    int pick, idx;
    record_t r;
    model_clear();
    idle();
    do_reset();
    check("reset_rec_bits", 128'(bus.rec_bits), 128'(0));

    // Fill the table, then free idx1
    for (int i = 0; i < 4; i++) enq(i + 4, i);
    #1;
    check("full_ready", 128'(bus.enq_ready), 128'(0));
    bus.fin_valid     = 1'b1;
    bus.fin_instIndex = 3'd1;
    #1;
    check("fin_same_cycle_ready", 128'(bus.enq_ready), 128'(m_bypass()));
    step();
    idle();
    #1;
    check("fin_next_cycle_ready", 128'(bus.enq_ready), 128'(1));

    // Mask update and out-of-footprint write
    do_reset();
    enq(8, 0);
    wr(9, 5, 0);
    check("mask_2000", 128'(bus.rec_bits[0].elementMask), 128'(64'h2000));
    wr(16, 3, 0);
    check("mask_unchanged", 128'(bus.rec_bits[0].elementMask), 128'(64'h2000));

    // RAW hit clears once the group is written
    do_reset();
    enq(8, 0);
    rd(8, 0, 1);
    check("raw_pending", 128'(bus.rd_conflict), 128'(1));
    wr(8, 0, 0);
    rd(8, 0, 1);
    check("raw_written", 128'(bus.rd_conflict), 128'(0));

    // Wrapped age comparisons
    do_reset();
    enq(3, 6);
    rd(3, 2, 1);
    check("wrap_older", 128'(bus.rd_conflict), 128'(1));
    do_reset();
    enq(3, 1);
    rd(3, 2, 6);
    check("wrap_younger", 128'(bus.rd_conflict), 128'(0));

    // Finish beats a same-cycle write
    do_reset();
    enq(4, 2);
    bus.wr_valid      = 1'b1;
    bus.wr_vd         = 5'd4;
    bus.wr_offset     = 3'd1;
    bus.wr_instIndex  = 3'd2;
    bus.fin_valid     = 1'b1;
    bus.fin_instIndex = 3'd2;
    step();
    idle();
    check("fin_wr_valid", 128'(bus.rec_valid[0]), 128'(0));
    check("fin_wr_mask", 128'(bus.rec_bits[0].elementMask), 128'(0));

    // Asynchronous reset with a conflict outstanding
    do_reset();
    enq(10, 0);
    enq(12, 1);
    bus.rd_valid     = 1'b1;
    bus.rd_vs        = 5'd10;
    bus.rd_instIndex = 3'd2;
    step();
    check("pre_reset_conflict", 128'(bus.rd_conflict), 128'(1));
    do_reset();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      idle();
      vq.delete();
      used.delete();
      for (int i = 0; i < SLOTS; i++) if (m_valid[i]) begin
        vq.push_back(i);
        used.push_back(int'(m_rec[i].instIndex));
      end
      if ($urandom_range(0, 1) == 1) begin
        do idx = $urandom_range(0, 7); while (idx inside {used});
        r           = '0;
        r.vd_valid  = ($urandom_range(0, 7) != 0);
        r.vd        = 5'($urandom_range(0, 31));
        r.vs1_valid = 1'($urandom);
        r.vs1       = 5'($urandom);
        r.vs2       = 5'($urandom);
        r.instIndex = IDX_W'(idx);
        r.gather    = 1'($urandom);
        r.gather16  = 1'($urandom);
        r.onlyRead  = 1'($urandom);
        r.elementMask = 64'($urandom);
        bus.enq_valid = 1'b1;
        bus.enq_rec   = r;
      end
      if (vq.size() > 0) begin
        if ($urandom_range(0, 9) < 7) begin
          pick = vq[$urandom_range(0, vq.size() - 1)];
          bus.wr_valid     = 1'b1;
          bus.wr_vd        = 5'(int'(m_rec[pick].vd) + $urandom_range(0, 9));
          bus.wr_offset    = OFF_W'($urandom);
          bus.wr_instIndex = m_rec[pick].instIndex;
        end
        if ($urandom_range(0, 9) < 2) begin
          pick = vq[$urandom_range(0, vq.size() - 1)];
          bus.fin_valid     = 1'b1;
          bus.fin_instIndex = m_rec[pick].instIndex;
        end
        if ($urandom_range(0, 9) < 8) begin
          pick = vq[$urandom_range(0, vq.size() - 1)];
          bus.rd_valid     = 1'b1;
          bus.rd_vs        = 5'(int'(m_rec[pick].vd) + $urandom_range(0, 9));
          bus.rd_offset    = OFF_W'($urandom);
          bus.rd_instIndex = IDX_W'($urandom_range(0, 7));
        end
      end
      step();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
